// File: rtl/f7_logic_arbiter_pkg.sv
// Shared definitions for the two-requester OR/NOR logic arbiter:
// sequencer state encoding and logic-unit op select codes.
package f7_logic_arbiter_pkg;

    // Sequencer states; the unused encoding 2'd3 recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Op select encoding seen by the shared logic unit.
    localparam logic OP_OR  = 1'b0;
    localparam logic OP_NOR = 1'b1;

endpackage

// File: rtl/f7_logic_arbiter_unit.sv
// Shared W-bit logic unit: per bit s = sel ? ~(a|b) : (a|b).
// Built from gate primitives so each bit is an explicit OR/NOR pair
// steered by sel through an AND-OR mux.
module f7_logic_unit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output wire  [W-1:0] s
);

    wire selN;

    not uSelInv (selN, sel);

    // One OR/NOR cell per bit, selected by sel.
    for (genvar i = 0; i < W; i++) begin : gBit
        wire orBit;
        wire norBit;
        wire orPick;
        wire norPick;

        or  uOr      (orBit,   a[i],   b[i]);
        nor uNor     (norBit,  a[i],   b[i]);
        and uOrPick  (orPick,  orBit,  selN);
        and uNorPick (norPick, norBit, sel);
        or  uMux     (s[i],    orPick, norPick);
    end

endmodule

// File: rtl/f7_logic_arbiter.sv
// Round-robin arbiter sharing one OR/NOR logic unit between two
// requesters. A three-state sequencer latches the granted operands,
// computes for one cycle, then holds the result until it is consumed.
module f7_logic_arbiter
    import f7_logic_arbiter_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic             req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] done_count
);

    state_t           state_q;
    state_t           state_d;
    logic             lastGrant_q;
    logic [W-1:0]     opA_q;
    logic [W-1:0]     opB_q;
    logic             opSel_q;
    logic             opId_q;
    logic [W-1:0]     rspData_q;
    logic             rspId_q;
    logic [CNT_W-1:0] doneCount_q;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             consume;
    wire  [W-1:0]     unitOut;

    // Round-robin grant: a lone valid always wins; on contention the
    // requester that was not served last goes next.
    always_comb begin
        grant0  = req0_valid & (~req1_valid | lastGrant_q);
        grant1  = req1_valid & (~req0_valid | ~lastGrant_q);
        req0_ready = (state_q == IDLE) & grant0;
        req1_ready = (state_q == IDLE) & grant1;
        accept  = req0_ready | req1_ready;
        consume = (state_q == RESP) & rsp_ready;
    end

    // Sequencer next state: accept -> compute one cycle -> hold until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = EXEC;
            EXEC:                 state_d = RESP;
            RESP:    if (consume) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture at the accept edge only; later operand changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            opA_q   <= '0;
            opB_q   <= '0;
            opSel_q <= OP_OR;
            opId_q  <= 1'b0;
        end else if (accept) begin
            opA_q   <= req1_ready ? req1_a   : req0_a;
            opB_q   <= req1_ready ? req1_b   : req0_b;
            opSel_q <= req1_ready ? req1_sel : req0_sel;
            opId_q  <= req1_ready;
        end
    end

    f7_logic_unit #(.W(W)) uUnit (
        .a   (opA_q),
        .b   (opB_q),
        .sel (opSel_q),
        .s   (unitOut)
    );

    // Result capture in EXEC; the result stays frozen through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rspData_q <= '0;
            rspId_q   <= 1'b0;
        end else if (state_q == EXEC) begin
            rspData_q <= unitOut;
            rspId_q   <= opId_q;
        end
    end

    // Response handshake bookkeeping: count deliveries and remember who was served.
    always_ff @(posedge clk) begin
        if (rst) begin
            doneCount_q <= '0;
            lastGrant_q <= 1'b1;
        end else if (consume) begin
            doneCount_q <= doneCount_q + CNT_W'(1);
            lastGrant_q <= rspId_q;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_data   = rspData_q;
    assign rsp_id     = rspId_q;
    assign done_count = doneCount_q;

endmodule
